cross_bar_slave_mem: RTL and testbench

//  Synthesizable word-addressed RAM endpoint on one cross_bar_top slave port. It sits directly downstream of the crossbar.

---
 rtl/cross_bar_slave_mem.sv | 145 ++++++++++++++
 tb/tb_cross_bar_slave_mem.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_slave_mem.sv
// Word-addressed RAM endpoint for one crossbar slave port, fixed wait states.
// Define CROSS_BAR_SLAVE_MEM_ERR_EN for slave_err and an out-of-range check.
module cross_bar_slave_mem #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SLAVE_W     = 2,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata
`ifdef CROSS_BAR_SLAVE_MEM_ERR_EN
  ,
  output logic              slave_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_REL
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic              cmd_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              oor;
  logic              do_ack;
  logic              unused_addr;

  assign idx    = addr_q[2 +: IDX_W];
  assign do_ack = (state == S_ACK);

`ifdef CROSS_BAR_SLAVE_MEM_ERR_EN
  assign oor = |addr_q[ADDR_W-SLAVE_W-1 : 2+IDX_W];
  assign unused_addr =
    ^{addr_q[1:0], addr_q[ADDR_W-1 -: SLAVE_W]};
`else
  assign oor = 1'b0;
  assign unused_addr =
    ^{addr_q[1:0], addr_q[ADDR_W-1 : 2+IDX_W]};
`endif

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (slave_req) begin
          state_nx = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == CNT_ONE) begin
          state_nx = S_ACK;
        end
      end
      S_ACK: state_nx = S_REL;
      S_REL: begin
        // req stays high past ack; wait for it to drop
        if (!slave_req) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      cnt     <= '0;
    end else if (state == S_IDLE && slave_req) begin
      addr_q  <= slave_addr;
      cmd_q   <= slave_cmd;
      wdata_q <= slave_wdata;
      cnt     <= CNT_LD;
    end else if (state == S_WAIT) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      slave_ack   <= 1'b0;
      slave_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      slave_ack <= do_ack;
      if (do_ack) begin
        if (oor) begin
          if (!cmd_q) begin
            slave_rdata <= ERR_DATA;
          end
        end else if (cmd_q) begin
          mem[idx] <= wdata_q;
        end else begin
          slave_rdata <= mem[idx];
        end
      end
    end
  end

`ifdef CROSS_BAR_SLAVE_MEM_ERR_EN
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      slave_err <= 1'b0;
    end else begin
      slave_err <= do_ack & oor;
    end
  end
`endif

endmodule

// File: tb/tb_cross_bar_slave_mem.sv
// Bench for cross_bar_slave_mem: WAIT_CYCLES=2 instance (d=0)
// and WAIT_CYCLES=0 instance (d=1), scoreboard on ack.
module tb_cross_bar_slave_mem;

  typedef struct {
    logic [31:0] a;
    logic        c;
    logic [31:0] wd;
    int          hold;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        e;
  } exp_t;

  logic             clk = 1'b0;
  logic             aresetn;
  logic [1:0]       req;
  logic [1:0]       cmd;
  logic [1:0]       ack;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][31:0] rdata;
`ifdef CROSS_BAR_SLAVE_MEM_ERR_EN
  logic [1:0]       err;
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  exp_t q0[$];
  exp_t q1[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cross_bar_slave_mem #(.WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .slave_req  (req[0]),
    .slave_addr (addr[0]),
    .slave_cmd  (cmd[0]),
    .slave_wdata(wdata[0]),
    .slave_ack  (ack[0]),
    .slave_rdata(rdata[0])
`ifdef CROSS_BAR_SLAVE_MEM_ERR_EN
    ,
    .slave_err  (err[0])
`endif
  );

  cross_bar_slave_mem #(.WAIT_CYCLES(0)) dut_w0 (
    .clk        (clk),
    .aresetn    (aresetn),
    .slave_req  (req[1]),
    .slave_addr (addr[1]),
    .slave_cmd  (cmd[1]),
    .slave_wdata(wdata[1]),
    .slave_ack  (ack[1]),
    .slave_rdata(rdata[1])
`ifdef CROSS_BAR_SLAVE_MEM_ERR_EN
    ,
    .slave_err  (err[1])
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               nm, act, exp);
    end
  endtask

  // scoreboard: pop one expectation per ack
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (ack[d]) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          chk("unexpected_ack", 32'(d), 32'hFFFF_FFFF);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk(d == 0 ? "rdata_w2" : "rdata_w0", rdata[d], e.rd);
`ifdef CROSS_BAR_SLAVE_MEM_ERR_EN
          chk("err_on_ack", 32'(err[d]), 32'(e.e));
`endif
        end
      end
`ifdef CROSS_BAR_SLAVE_MEM_ERR_EN
      else if (err[d]) begin
        chk("err_without_ack", 32'(err[d]), 32'd0);
      end
`endif
    end
  end

  // entered and left at a negedge
  task automatic txn(input int d, input logic [31:0] a,
                     input logic c, input logic [31:0] wd,
                     input int hold, input logic [31:0] er,
                     input logic ee);
    exp_t e;
    int   n;
    int   lat;
    lat  = (d == 0) ? 4 : 2;
    e.rd = er;
    e.e  = ee;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    req[d]   = 1'b1;
    addr[d]  = a;
    cmd[d]   = c;
    wdata[d] = wd;
    @(posedge clk);
    #1;
    addr[d]  = ~a;
    cmd[d]   = ~c;
    wdata[d] = ~wd;
    @(negedge clk);
    n = 1;
    while (!ack[d] && n < lat + 6) begin
      @(negedge clk);
      n++;
    end
    chk(d == 0 ? "latency_w2" : "latency_w0", 32'(n), 32'(lat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("ack_while_req_held", 32'(ack[d]), 32'd0);
    end
    req[d] = 1'b0;
    @(negedge clk);
    chk("ack_single_cycle", 32'(ack[d]), 32'd0);
  endtask

  vec_t        v[10];
  logic [31:0] w0v[4];

  initial begin
    v[0] = '{32'h0000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0};
    v[1] = '{32'h0000_0004, 1'b1, 32'h89AB_CDEF, 0, 32'h0, 1'b0};
    v[2] = '{32'h0000_0004, 1'b0, 32'h0, 0, 32'h89AB_CDEF, 1'b0};
    v[3] = '{32'h0000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0};
    v[4] = '{32'h0000_0008, 1'b1, 32'h00FF_00FF, 2, 32'h0, 1'b0};
    v[5] = '{32'h0000_0008, 1'b0, 32'h0, 0, 32'h00FF_00FF, 1'b0};
    v[6] = '{32'h0000_0040, 1'b1, 32'h0123_4567, 0,
             32'h00FF_00FF, ERR_ON};
    v[7] = '{32'h0000_0000, 1'b0, 32'h0, 0,
             ERR_ON ? 32'h0 : 32'h0123_4567, 1'b0};
    v[8] = '{32'h0000_0040, 1'b0, 32'h0, 0,
             ERR_ON ? 32'hDEAD_BEEF : 32'h0123_4567, ERR_ON};
    v[9] = '{32'hC000_0006, 1'b0, 32'h0, 0, 32'h89AB_CDEF, 1'b0};
    w0v = '{32'h1111_0000, 32'h2222_0004,
            32'h3333_0008, 32'h4444_000C};

    aresetn = 1'b0;
    req = '0;
    cmd = '0;
    addr = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ack", 32'(ack[d]), 32'd0);
      chk("reset_rdata", rdata[d], 32'h0);
    end

    for (int i = 0; i < 10; i++) begin
      txn(0, v[i].a, v[i].c, v[i].wd, v[i].hold, v[i].er, v[i].ee);
    end

    // reset while the write is in WAIT: must be dropped
    req[0]   = 1'b1;
    cmd[0]   = 1'b1;
    addr[0]  = 32'h0000_000C;
    wdata[0] = 32'h5A5A_5A5A;
    @(negedge clk);
    aresetn = 1'b0;
    req[0]  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ack_after_reset", 32'(ack[0]), 32'd0);
    end
    aresetn = 1'b1;
    @(negedge clk);
    chk("rdata_cleared", rdata[0], 32'h0);
    txn(0, 32'h0000_000C, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    txn(0, 32'h0000_0004, 1'b0, 32'h0, 0, 32'h0, 1'b0);

    // zero wait states, back-to-back
    for (int i = 0; i < 4; i++) begin
      txn(1, 32'(i * 4), 1'b1, w0v[i], 0, 32'h0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      txn(1, 32'(i * 4), 1'b0, 32'h0, 0, w0v[i], 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("missing_acks", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
